// File: rtl/rvga_types.sv
// Shared RVGA pipeline types: control word, load funct3 encodings and the
// writeback FSM state enum.
package rvga_types;

  typedef logic [31:0] rvga_word;
  typedef logic [4:0]  rvga_reg;

  typedef struct packed {
    logic        valid;
    rvga_word    pc;
    logic        mem_load;
    logic        mem_store;
    logic [2:0]  funct3;
    rvga_reg     rd;
    rvga_word    rd_data;
    logic        regfile_load;
  } rvga_cword;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } wb_state_e;

  function automatic logic is_load_f3(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/wback_load_align.sv
// Load lane select and sign/zero extension; unsupported funct3 yields zero.
module load_align
  import rvga_types::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] offset,
  input  rvga_word   word,
  output rvga_word   data
);

  logic [7:0]  byte_l;
  logic [15:0] half_l;

  always_comb begin
    byte_l = word[{offset, 3'b000} +: 8];
    half_l = word[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   data = {{24{byte_l[7]}}, byte_l};
      F3_LH:   data = {{16{half_l[15]}}, half_l};
      F3_LW:   data = word;
      F3_LBU:  data = {24'd0, byte_l};
      F3_LHU:  data = {16'd0, half_l};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wback.sv
// Writeback stage: commits ALU results and aligned load data, stalling while a
// load is outstanding. Define WB_INSTRET_EN to add the 64-bit instret counter.
module wback
  import rvga_types::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  rvga_cword       mem_wb_cword,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output rvga_cword       wb_rf_cword,
  output logic            wb_stall,
  output logic            load_fault
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  if (XLEN != $bits(rvga_word)) begin : g_xlen_chk
    $error("wback: XLEN must equal the width of rvga_word");
  end

  localparam logic [16:0] TO_LAST = 17'(LOAD_TIMEOUT - 1);

  wb_state_e   state, state_nxt;
  logic [15:0] cnt;
  rvga_reg     lat_rd;
  logic [2:0]  lat_f3;
  logic [1:0]  lat_off;

  logic        issue_load, timeout, stall_c;
  logic [2:0]  al_f3;
  logic [1:0]  al_off;
  rvga_reg     al_rd;
  rvga_word    al_data;
  rvga_cword   cw_nxt, ld_word;

  assign issue_load = mem_wb_cword.valid & mem_wb_cword.mem_load;
  // Compared one ahead so the FAULT transition lands as the counter reaches LOAD_TIMEOUT-1.
  assign timeout    = ({1'b0, cnt} + 17'd1) >= TO_LAST;

  // The aligner sees the live cword in IDLE and the latched load in WAIT.
  assign al_f3  = (state == WAIT) ? lat_f3  : mem_wb_cword.funct3;
  assign al_off = (state == WAIT) ? lat_off : mem_wb_cword.rd_data[1:0];
  assign al_rd  = (state == WAIT) ? lat_rd  : mem_wb_cword.rd;

  load_align u_align (
    .funct3 (al_f3),
    .offset (al_off),
    .word   (dmem_rdata),
    .data   (al_data)
  );

  always_comb begin
    ld_word              = '0;
    ld_word.valid        = 1'b1;
    ld_word.mem_load     = 1'b1;
    ld_word.funct3       = al_f3;
    ld_word.rd           = al_rd;
    ld_word.rd_data      = al_data;
    ld_word.regfile_load = is_load_f3(al_f3) && (al_rd != '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (issue_load && !dmem_rvalid) state_nxt = WAIT;
      WAIT:    if (dmem_rvalid)  state_nxt = IDLE;
               else if (timeout) state_nxt = FAULT;
      FAULT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: stall and the word to commit next cycle
  always_comb begin
    stall_c = 1'b0;
    cw_nxt  = '0;
    case (state)
      IDLE: begin
        if (mem_wb_cword.valid && !mem_wb_cword.mem_load) begin
          cw_nxt              = mem_wb_cword;
          cw_nxt.regfile_load = mem_wb_cword.regfile_load && (mem_wb_cword.rd != '0);
        end else if (issue_load) begin
          if (dmem_rvalid) cw_nxt  = ld_word;
          else             stall_c = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_rvalid) cw_nxt  = ld_word;
        else             stall_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign wb_stall = rst_n & stall_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      lat_rd      <= '0;
      lat_f3      <= '0;
      lat_off     <= '0;
      wb_rf_cword <= '0;
      load_fault  <= 1'b0;
    end else begin
      if (state == IDLE && issue_load && !dmem_rvalid) begin
        cnt     <= '0;
        lat_rd  <= mem_wb_cword.rd;
        lat_f3  <= mem_wb_cword.funct3;
        lat_off <= mem_wb_cword.rd_data[1:0];
      end else if (state == WAIT && !dmem_rvalid) begin
        cnt <= cnt + 16'd1;
      end
      wb_rf_cword <= cw_nxt;
      load_fault  <= (state_nxt == FAULT);
    end
  end

`ifdef WB_INSTRET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret <= '0;
    else        instret <= instret + 64'(cw_nxt.valid);
  end
`endif

endmodule

// File: doc/wback.md
WBACK -- requirements
Module: wback

Interface
REQ-001 Parameter XLEN, 32, data width; SHALL equal the width of rvga_word.
REQ-002 Parameter LOAD_TIMEOUT, 255, maximum number of WAIT cycles before a load is abandoned; SHALL be 1 to 65535.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 mem_wb_cword  in  rvga_cword  control word from the memory stage; this block SHALL use only the fields valid, mem_load, funct3, rd, rd_data and regfile_load.
REQ-006 dmem_rvalid  in  1  data-memory read response valid.
REQ-007 dmem_rdata  in  XLEN  aligned 32-bit read word; SHALL be sampled only while dmem_rvalid=1.
REQ-008 wb_rf_cword  out  rvga_cword  registered writeback word for the register-fetch stage (fields rd, rd_data, regfile_load).
REQ-009 wb_stall  out  1  combinational; holds the upstream pipeline while a load is outstanding.
REQ-010 load_fault  out  1  registered one-cycle pulse when a load times out.

Function
REQ-011 The FSM SHALL have the states IDLE, WAIT and FAULT.
REQ-012 IDLE, with mem_wb_cword.valid=1 and mem_load=0: wb_rf_cword SHALL equal the input on the next cycle (1-cycle latency).
REQ-013 IDLE, with a valid load and dmem_rvalid=1 in the same cycle: the block SHALL commit the extended data on the next cycle, SHALL keep wb_stall=0 and SHALL stay in IDLE.
REQ-014 IDLE, with a valid load and dmem_rvalid=0: the block SHALL latch rd and funct3 and the offset rd_data[1:0], SHALL go to WAIT, SHALL clear the timeout counter and SHALL drive wb_stall=1 that cycle.
REQ-015 WAIT: wb_stall SHALL be 1 while dmem_rvalid=0; the input cword SHALL be ignored.
REQ-016 WAIT, when dmem_rvalid=1: wb_stall SHALL be 0 that cycle, the extended data SHALL be committed on the next cycle, the next state SHALL be IDLE, and the input cword in that cycle SHALL NOT be accepted.
REQ-017 The counter SHALL increment each WAIT cycle without rvalid.
REQ-018 When the counter reaches LOAD_TIMEOUT-1 without rvalid, the next state SHALL be FAULT.
REQ-019 If dmem_rvalid and the timeout occur in the same cycle, dmem_rvalid SHALL take priority.
REQ-020 FAULT, lasting one cycle: load_fault=1, wb_rf_cword.regfile_load=0, wb_stall=0; the next state SHALL be IDLE.
REQ-021 Load extension by funct3:
- 000 LB: sign-extended byte.
- 001 LH: sign-extended half.
- 010 LW: full word.
- 100 LBU: zero-extended byte.
- 101 LHU: zero-extended half.
- Lane select: byte = offset; half = offset[1]; LW ignores offset.
- Other funct3 values: rd_data=0 and regfile_load=0.
REQ-022 regfile_load SHALL be driven to 0 whenever rd=0 or valid=0.
REQ-023 A dmem_rvalid with no load outstanding SHALL be ignored.
REQ-024 In a cycle with no commit, wb_rf_cword SHALL be driven to all-zero.

Reset
REQ-025 rst_n low SHALL immediately force:
- FSM state IDLE;
- counter 0;
- wb_rf_cword all-zero;
- load_fault 0;
- wb_stall 0;
- instret 0.
REQ-026 An outstanding load interrupted by reset SHALL be discarded, and a late dmem_rvalid after reset SHALL be ignored.

Configuration
REQ-027 Macro WB_INSTRET_EN SHALL control the instret output.
REQ-028 Defined: the port instret (out, 64) SHALL exist and SHALL increment by 1 on every commit with valid=1; FAULT cycles SHALL NOT count, and the counter SHALL wrap at 2^64.
REQ-029 Undefined: the port and the counter SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-030 The load funct3 encodings (LB, LH, LW, LBU, LHU) and the FSM state enum SHALL reside in the shared rvga_types package; rvga_cword SHALL remain defined there.
REQ-031 Lane select and extension SHALL be a combinational sub-module named load_align, with inputs funct3, offset and word, and output data.

Verification
REQ-032 Input ALU op rd=5, rd_data=0x00001234, regfile_load=1 -> next cycle wb_rf_cword rd=5, rd_data=0x00001234, regfile_load=1; wb_stall never 1.
REQ-033 Input LB at offset 3, rvalid 2 cycles later with rdata=0x80FF0000 -> wb_stall=1 for 2 cycles, then rd_data=0xFFFFFF80.
REQ-034 Input LHU at offset 2, rvalid in the same cycle with rdata=0x80011234 -> rd_data=0x00008001; wb_stall=0 throughout.
REQ-035 LOAD_TIMEOUT=4, load with no rvalid -> 4 stall cycles, then load_fault pulse with regfile_load=0, then IDLE.
REQ-036 ALU op with rd=0 -> regfile_load=0; with WB_INSTRET_EN defined, instret still increments by 1.
REQ-037 rst_n low in WAIT, then rvalid after release -> all outputs zero and no commit occurs.
